// File: rtl/aes_mixcol_seq.sv
// AES MixColumns sequencer: one shared GF(2^8) multiply-accumulate unit, 64 steps per state.
// Optional AES_MIXCOL_BYPASS_EN adds last_round, which skips MixColumns and echoes the input.
module aes_mixcol_seq #(
  parameter int NCOL = 4,
  parameter int NROW = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] state0,
  input  logic [31:0] state1,
  input  logic [31:0] state2,
  input  logic [31:0] state3,
`ifdef AES_MIXCOL_BYPASS_EN
  input  logic        last_round,
`endif
  output logic [31:0] state_out0,
  output logic [31:0] state_out1,
  output logic [31:0] state_out2,
  output logic [31:0] state_out3,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                r_state;
  logic [1:0]            r_k;
  logic [1:0]            r_row;
  logic [1:0]            r_col;
  logic [7:0]            r_acc;
  // Byte [c][3-r] holds row r of column c, so each column is its 32-bit word with row 0 at the MSB
  logic [3:0][3:0][7:0]  r_in;
  logic [3:0][3:0][7:0]  r_buf;
  logic [3:0][31:0]      r_out;
  logic                  r_busy;
  logic                  r_done;

  logic [3:0][31:0]      w_cols;
  logic [7:0]            w_b;
  logic [1:0]            w_y;
  logic [7:0]            w_prod;
  logic [7:0]            w_acc_next;
  logic [3:0][3:0][7:0]  w_buf_next;
  logic [5:0]            w_cnt_next;
  logic                  w_last;

  function automatic logic [7:0] gf_mul(input logic [1:0] y, input logic [7:0] b);
    logic [7:0] x2;
    x2 = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    case (y)
      2'd1:    gf_mul = b;
      2'd2:    gf_mul = x2;
      2'd3:    gf_mul = x2 ^ b;
      default: gf_mul = '0;
    endcase
  endfunction

  // The MixColumns matrix is circulant: the coefficient depends only on (k - row) mod 4
  function automatic logic [1:0] coef(input logic [1:0] row, input logic [1:0] k);
    logic [1:0] d;
    d = k - row;
    case (d)
      2'd0:    coef = 2'd2;
      2'd1:    coef = 2'd3;
      default: coef = 2'd1;
    endcase
  endfunction

  assign w_cols     = {state3, state2, state1, state0};
  assign w_b        = r_in[r_col][2'd3 - r_k];
  assign w_y        = coef(r_row, r_k);
  assign w_prod     = gf_mul(w_y, w_b);
  assign w_acc_next = r_acc ^ w_prod;
  assign w_cnt_next = {r_col, r_row, r_k} + 6'd1;
  assign w_last     = &{r_col, r_row, r_k};

  always_comb begin
    w_buf_next = r_buf;
    if (r_k == 2'd3) begin
      w_buf_next[r_col][2'd3 - r_row] = w_acc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_acc   <= '0;
      r_in    <= '0;
      r_buf   <= '0;
      r_out   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int unsigned c = 0; c < NCOL; c++) begin
              r_in[c] <= w_cols[c];
            end
            r_busy  <= 1'b1;
            r_state <= S_RUN;
`ifdef AES_MIXCOL_BYPASS_EN
            if (last_round) begin
              r_out   <= w_cols;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
`endif
          end
        end
        S_RUN: begin
          r_acc <= (r_k == 2'd3) ? 8'h00 : w_acc_next;
          r_buf <= w_buf_next;
          {r_col, r_row, r_k} <= w_cnt_next;
          if (w_last) begin
            // Load from the next-buffer view so the final byte lands in the same edge
            for (int unsigned c = 0; c < NCOL; c++) begin
              r_out[c] <= w_buf_next[c];
            end
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign state_out0 = r_out[0];
  assign state_out1 = r_out[1];
  assign state_out2 = r_out[2];
  assign state_out3 = r_out[3];
  assign busy       = r_busy;
  assign done       = r_done;

  logic [31:0] w_unused_par;
  assign w_unused_par = 32'(NROW);

endmodule

// File: tb/tb_aes_mixcol_seq.sv
// Directed bench for aes_mixcol_seq with a scoreboard of expected states popped on done.
module tb_aes_mixcol_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] s0, s1, s2, s3;
  logic [31:0] o0, o1, o2, o3;
  logic        busy, done;
`ifdef AES_MIXCOL_BYPASS_EN
  logic        last_round;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [127:0] exp_q[$];

  always #5 clk = ~clk;

  aes_mixcol_seq #(.NCOL(4), .NROW(4)) dut (
    .clk(clk), .reset(reset), .start(start),
    .state0(s0), .state1(s1), .state2(s2), .state3(s3),
`ifdef AES_MIXCOL_BYPASS_EN
    .last_round(last_round),
`endif
    .state_out0(o0), .state_out1(o1), .state_out2(o2), .state_out3(o3),
    .busy(busy), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mc(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  task automatic set_in(input logic [31:0] a, b, c, d);
    s0 = a; s1 = b; s2 = c; s3 = d;
  endtask

  task automatic check_result(input string tag);
    logic [127:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, " sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, " col0"}, o0, e[127:96]);
      chk({tag, " col1"}, o1, e[95:64]);
      chk({tag, " col2"}, o2, e[63:32]);
      chk({tag, " col3"}, o3, e[31:0]);
    end
  endtask

  task automatic wait_done(input string tag, output int at);
    at = -1;
    for (int n = 0; n < 200 && done !== 1'b1; n++) tick();
    if (done === 1'b1) at = cyc;
    else chk({tag, " done_timeout"}, {31'd0, done}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, b, c, d, input logic [127:0] e);
    int t0, at;
    set_in(a, b, c, d);
    exp_q.push_back(e);
    t0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, " busy_run"}, {31'd0, busy}, 32'd1);
    wait_done(tag, at);
    if (at >= 0) begin
      chk({tag, " latency"}, at - t0, 32'd65);
      chk({tag, " busy_done"}, {31'd0, busy}, 32'd1);
      check_result(tag);
      tick();
      chk({tag, " done_pulse"}, {31'd0, done}, 32'd0);
      chk({tag, " busy_idle"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    int t0, at0, at1, at2, n_done, first_at, cur;
    logic [31:0] v [3][4];

    reset = 1'b1;
    start = 1'b0;
    set_in('0, '0, '0, '0);
`ifdef AES_MIXCOL_BYPASS_EN
    last_round = 1'b0;
`endif
    repeat (3) tick();
    reset = 1'b0;
    chk("rst out0", o0, 32'h0);
    chk("rst out3", o3, 32'h0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);

    // FIPS-197 column
    run_op("fips", 32'hdb135345, 32'h0, 32'h0, 32'h0, {32'h8e4da1bc, 32'h0, 32'h0, 32'h0});

    // Stray starts during RUN, inputs scrambled after capture, previous result held
    set_in(32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5);
    exp_q.push_back({32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6});
    t0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    set_in($urandom, $urandom, $urandom, $urandom);
    n_done = 0;
    first_at = -1;
    for (int i = 0; i < 150; i++) begin
      cur = cyc - t0;
      if (done === 1'b1) begin
        n_done++;
        if (first_at < 0) begin
          first_at = cur;
          check_result("ignore");
        end
      end
      if (cur == 50) chk("hold out0", o0, 32'h8e4da1bc);
      start = (cur == 10 || cur == 40);
      tick();
    end
    start = 1'b0;
    chk("ignore n_done", n_done, 32'd1);
    chk("ignore latency", first_at, 32'd65);

    // Reset in the middle of RUN
    set_in(32'h2d26314c, 32'h0, 32'h0, 32'h0);
    t0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc - t0 < 30) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort out0", o0, 32'h0);
    chk("abort out1", o1, 32'h0);
    chk("abort out3", o3, 32'h0);
    n_done = 0;
    for (int i = 0; i < 100; i++) begin
      if (done === 1'b1) n_done++;
      tick();
    end
    chk("abort no_done", n_done, 32'd0);

    run_op("after_abort", 32'h2d26314c, 32'h0, 32'h0, 32'h0, {32'h4d7ebdf8, 32'h0, 32'h0, 32'h0});

    // Back-to-back with start held high
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 4; j++) v[i][j] = $urandom;
    start = 1'b1;
    set_in(v[0][0], v[0][1], v[0][2], v[0][3]);
    exp_q.push_back({mc(v[0][0]), mc(v[0][1]), mc(v[0][2]), mc(v[0][3])});
    tick();
    set_in(v[1][0], v[1][1], v[1][2], v[1][3]);
    exp_q.push_back({mc(v[1][0]), mc(v[1][1]), mc(v[1][2]), mc(v[1][3])});
    wait_done("b2b0", at0);
    check_result("b2b0");
    tick();
    tick();
    set_in(v[2][0], v[2][1], v[2][2], v[2][3]);
    exp_q.push_back({mc(v[2][0]), mc(v[2][1]), mc(v[2][2]), mc(v[2][3])});
    wait_done("b2b1", at1);
    chk("b2b gap1", at1 - at0, 32'd66);
    check_result("b2b1");
    tick();
    tick();
    start = 1'b0;
    set_in('0, '0, '0, '0);
    wait_done("b2b2", at2);
    chk("b2b gap2", at2 - at1, 32'd66);
    check_result("b2b2");
    repeat (3) tick();
    chk("b2b idle busy", {31'd0, busy}, 32'd0);

`ifdef AES_MIXCOL_BYPASS_EN
    set_in(32'hdb135345, 32'h0, 32'h0, 32'h0);
    last_round = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    last_round = 1'b0;
    chk("byp done", {31'd0, done}, 32'd1);
    chk("byp busy", {31'd0, busy}, 32'd1);
    chk("byp out0", o0, 32'hdb135345);
    tick();
    chk("byp done_pulse", {31'd0, done}, 32'd0);
    chk("byp busy_idle", {31'd0, busy}, 32'd0);
`endif

    chk("sb drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
